// File: rtl/fetch_unit.sv
// Instruction fetch front end. It issues one-word reads under a credit rule and buffers
// the responses in a small FIFO, which then presents them in order to the consumer.
module fetch_unit #(
   parameter logic [29:0] RESET_PC = 30'h0,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_re,
   output logic [29:0] memaddr,
   input  logic [31:0] rmemdata,
   input  logic        redirect,
   input  logic [29:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [29:0] inst_pc,
   input  logic        inst_ready
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [29:0]   fetch_pc;
   logic [29:0]   inflight_pc;
   logic          inflight;
   logic          kill;
   logic [CW-1:0] count;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW:0]   credit_used;
   logic          push;
   logic          pop;
   logic          flush;

   logic [31:0] buf_data [DEPTH];
   logic [29:0] buf_pc   [DEPTH];

   // A slot is reserved for every in-flight read, so the buffer can never overflow.
   assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign mem_re      = (state == RUN) && !redirect && (credit_used < DEPTH_C);
   assign memaddr     = fetch_pc;

   assign flush      = redirect && (state == RUN);
   assign inst_valid = (count != '0);
   assign pop        = inst_valid && inst_ready && !redirect;
   assign push       = inflight && !kill && !redirect;
   assign inst_data  = inst_valid ? buf_data[rd_ptr] : 32'h0;
   assign inst_pc    = inst_valid ? buf_pc[rd_ptr]   : 30'h0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         inflight_pc <= 30'h0;
         inflight    <= 1'b0;
         kill        <= 1'b0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         case (state)
            IDLE:    state <= RUN;
            default: state <= RUN;
         endcase

         inflight <= mem_re;
         kill     <= flush;
         if (mem_re)
            inflight_pc <= fetch_pc;

         if (redirect)
            fetch_pc <= redirect_pc;
         else if (mem_re)
            fetch_pc <= fetch_pc + 30'd1;

         if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   // Storage needs no reset: entries are only visible while count says they are live.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wr_ptr] <= rmemdata;
         buf_pc[wr_ptr]   <= inflight_pc;
      end
   end

endmodule
